// File: rtl/sha256_compress_if.sv
// Handshake bundle between the SHA-256 compressor and its feeder/consumer.
// SHA224_EN adds the mode224 request bit.
interface sha256_compress_if;
  logic         start;
  logic         init;
  logic [31:0]  w_in;
  logic         word_req;
  logic         sched_sel;
  logic         busy;
  logic         done;
  logic [255:0] digest;
`ifdef SHA224_EN
  logic         mode224;
`endif

  modport master (
    output start,
    output init,
    output w_in,
`ifdef SHA224_EN
    output mode224,
`endif
    input  word_req,
    input  sched_sel,
    input  busy,
    input  done,
    input  digest
  );

  modport slave (
    input  start,
    input  init,
    input  w_in,
`ifdef SHA224_EN
    input  mode224,
`endif
    output word_req,
    output sched_sel,
    output busy,
    output done,
    output digest
  );
endinterface

// File: rtl/sha256_compress.sv
// SHA-256 compression: 64 rounds on streamed W_t, chaining hash and digest.
// Optional macro SHA224_EN adds the SHA-224 IV and truncated digest.
module sha256_compress #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 6
) (
  input logic              clk,
  input logic              rst,
  sha256_compress_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL
  } state_e;

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

`ifdef SHA224_EN
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };
`endif

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      v_q  [8];
  logic [31:0]      hh_q [8];
  logic             done_q;
  logic             busy_q;
`ifdef SHA224_EN
  logic             mode_q;
`endif

  logic [31:0] iv_d [8];
  logic [31:0] k_d;
  logic [31:0] ch_d;
  logic [31:0] maj_d;
  logic [31:0] t1_d;
  logic [31:0] t2_d;
  logic        last_d;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      iv_d[i] = IV256[i];
`ifdef SHA224_EN
      if (bus.mode224) iv_d[i] = IV224[i];
`endif
    end
  end

  always_comb begin
    k_d   = K[cnt_q];
    ch_d  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
    maj_d = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2])
          ^ (v_q[1] & v_q[2]);
    t1_d  = v_q[7] + bsig1(v_q[4]) + ch_d + k_d + bus.w_in;
    t2_d  = bsig0(v_q[0]) + maj_d;
    last_d = (cnt_q == CNT_W'(ROUNDS - 1));
  end

  // Upstream handshakes decode the live round index, no pipeline delay.
  assign bus.word_req  = (state_q == ROUND) && (int'(cnt_q) < 16);
  assign bus.sched_sel = (state_q == ROUND) && (int'(cnt_q) >= 16);
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef SHA224_EN
  assign bus.digest = {hh_q[0], hh_q[1], hh_q[2], hh_q[3],
                       hh_q[4], hh_q[5], hh_q[6],
                       mode_q ? 32'h0 : hh_q[7]};
`else
  assign bus.digest = {hh_q[0], hh_q[1], hh_q[2], hh_q[3],
                       hh_q[4], hh_q[5], hh_q[6], hh_q[7]};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        v_q[i]  <= '0;
        hh_q[i] <= IV256[i];
      end
`ifdef SHA224_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ROUND;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            for (int i = 0; i < 8; i++) begin
              if (bus.init) begin
                hh_q[i] <= iv_d[i];
                v_q[i]  <= iv_d[i];
              end else begin
                v_q[i]  <= hh_q[i];
              end
            end
`ifdef SHA224_EN
            if (bus.init) mode_q <= bus.mode224;
`endif
          end
        end
        ROUND: begin
          v_q[0] <= t1_d + t2_d;
          v_q[1] <= v_q[0];
          v_q[2] <= v_q[1];
          v_q[3] <= v_q[2];
          v_q[4] <= v_q[3] + t1_d;
          v_q[5] <= v_q[4];
          v_q[6] <= v_q[5];
          v_q[7] <= v_q[6];
          cnt_q  <= cnt_q + 1'b1;
          if (last_d) state_q <= FINAL;
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) begin
            hh_q[i] <= hh_q[i] + v_q[i];
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
